// File: rtl/mvu_pkg.sv
// mvu_pkg: shared types and constants for the MVU memory port arbiter
package mvu_pkg;
  typedef enum logic {IDLE, HOLD} arb_state_e;
  localparam int ArbCntWidth = 4;
endpackage

// File: rtl/mvu_rr_pick.sv
// mvu_rr_pick: rotate-and-priority-encode; first set bit of req & ~excl at or after start, wrapping modulo N
module mvu_rr_pick #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic [N-1:0] excl,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [N-1:0] m;
  logic [W:0]   s;
  assign m = req & ~excl;
  // Scanning from the far end lets the candidate nearest to start overwrite the others.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    s     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      s = {1'b0, start} + (W+1)'(i);
      s = (s >= (W+1)'(N)) ? s - (W+1)'(N) : s;
      if (m[s[W-1:0]]) begin
        idx   = s[W-1:0];
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mvu_mem_port_arbiter.sv
// mvu_mem_port_arbiter: N-requester arbiter onto one single-port SRAM with one-cycle read latency
// Define MVU_MEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin with burst hold.
module mvu_mem_port_arbiter
  import mvu_pkg::*;
#(
  parameter int NumReq    = 3,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 32,
  parameter int MaxBurst  = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NumReq-1:0]                    req_i,
  input  logic [NumReq-1:0]                    we_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]   be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]     wdata_i,
  output logic [NumReq-1:0]                    gnt_o,
  output logic [NumReq-1:0]                    rvalid_o,
  output logic [DataWidth-1:0]                 rdata_o,
  output logic                                 mem_req_o,
  output logic                                 mem_we_o,
  output logic [AddrWidth-1:0]                 mem_addr_o,
  output logic [DataWidth/8-1:0]               mem_be_o,
  output logic [DataWidth-1:0]                 mem_wdata_o,
  input  logic [DataWidth-1:0]                 mem_rdata_i
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  logic [IdxW-1:0] pick_idx, gnt_idx, sel, rsp_idx_q;
  logic            pick_valid, gnt_valid, rsp_v_q;
`ifdef MVU_MEM_ARB_FIXED_PRIO_EN
  mvu_rr_pick #(.N(NumReq), .W(IdxW)) u_pick (
    .req   (req_i),
    .start ('0),
    .excl  ('0),
    .idx   (pick_idx),
    .valid (pick_valid)
  );
  assign gnt_idx   = pick_idx;
  assign gnt_valid = pick_valid & ~rst_i;
`else
  arb_state_e             state_q, state_d;
  logic [IdxW-1:0]        last_q, owner_q, owner_d, start;
  logic [ArbCntWidth-1:0] cnt_q, cnt_d;
  logic [NumReq-1:0]      owner_mask, excl;
  logic                   others, at_max, keep;
  assign owner_mask = NumReq'(1) << owner_q;
  assign excl       = (state_q == HOLD) ? owner_mask : '0;
  assign start      = (last_q == IdxW'(NumReq - 1)) ? '0 : last_q + IdxW'(1);
  mvu_rr_pick #(.N(NumReq), .W(IdxW)) u_pick (
    .req   (req_i),
    .start (start),
    .excl  (excl),
    .idx   (pick_idx),
    .valid (pick_valid)
  );
  // The owner keeps the port unless it drops req or has used its burst while someone else waits.
  always_comb begin
    others    = |(req_i & ~owner_mask);
    at_max    = cnt_q >= ArbCntWidth'(MaxBurst);
    keep      = (state_q == HOLD) && req_i[owner_q] && !(at_max && others);
    gnt_idx   = keep ? owner_q : pick_idx;
    gnt_valid = !rst_i && (keep || pick_valid);
    state_d   = gnt_valid ? HOLD : IDLE;
    owner_d   = gnt_valid ? gnt_idx : owner_q;
    cnt_d     = !gnt_valid ? '0 : !keep ? ArbCntWidth'(1) : at_max ? cnt_q : cnt_q + ArbCntWidth'(1);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      last_q  <= IdxW'(NumReq - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= gnt_valid ? gnt_idx : last_q;
    end
  end
`endif
  // With no grant the payload mux stays on the last granted requester.
  assign sel         = gnt_valid ? gnt_idx : rsp_idx_q;
  assign gnt_o       = gnt_valid ? NumReq'(1) << gnt_idx : '0;
  assign mem_req_o   = gnt_valid;
  assign mem_we_o    = gnt_valid & we_i[gnt_idx];
  assign mem_be_o    = gnt_valid ? be_i[gnt_idx] : '0;
  assign mem_addr_o  = addr_i[sel];
  assign mem_wdata_o = wdata_i[sel];
  assign rvalid_o    = (rsp_v_q && !rst_i) ? NumReq'(1) << rsp_idx_q : '0;
  assign rdata_o     = mem_rdata_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_v_q   <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      rsp_v_q   <= gnt_valid;
      rsp_idx_q <= sel;
    end
  end
endmodule

// File: tb/tb_mvu_mem_port_arbiter.sv
// tb_mvu_mem_port_arbiter: directed bench for the arbiter, with MaxBurst=4 and MaxBurst=1 instances
module tb_mvu_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0]       req, we;
  logic [2:0][31:0] addr, wdata;
  logic [2:0][3:0]  be;
  logic [31:0]      mem_rdata;
  logic [2:0]  gnt, rvalid, gnt1, rvalid1;
  logic [31:0] rdata, mem_addr, mem_wdata, rdata1, mem_addr1, mem_wdata1;
  logic        mem_req, mem_we, mem_req1, mem_we1;
  logic [3:0]  mem_be, mem_be1;
  int vectors = 0;
  int miscompares = 0;

  mvu_mem_port_arbiter #(.NumReq(3), .AddrWidth(32), .DataWidth(32), .MaxBurst(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );
  mvu_mem_port_arbiter #(.NumReq(3), .AddrWidth(32), .DataWidth(32), .MaxBurst(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be), .wdata_i(wdata),
    .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1), .mem_req_o(mem_req1), .mem_we_o(mem_we1),
    .mem_addr_o(mem_addr1), .mem_be_o(mem_be1), .mem_wdata_o(mem_wdata1), .mem_rdata_i(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    req = '0; we = '0; addr = '0; wdata = '0; be = '0; mem_rdata = '0;
    cyc; cyc;
    req = 3'b111;
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_gnt_mb1", gnt1, 0);
    req = '0; rst = 1'b0;
    cyc;
    addr[1] = 32'h10; mem_rdata = 32'hDEADBEEF; req = 3'b010;
    #1;
    chk("rd_gnt", gnt, 3'b010);
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_mem_addr", mem_addr, 32'h10);
    cyc;
    req = '0;
    #1;
    chk("rd_rvalid", rvalid, 3'b010);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("idle_gnt", gnt, 0);
    chk("idle_mem_be", mem_be, 0);
    cyc;
    chk("idle_rvalid", rvalid, 0);
    rst = 1'b1; cyc; rst = 1'b0;
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_gnt", gnt1, 3'b001 << (i % 3));
      if (i > 0) chk("rr_rvalid", rvalid1, 3'b001 << ((i - 1) % 3));
      cyc;
    end
    req = '0;
    #1;
    chk("rr_rvalid_last", rvalid1, 3'b100);
    cyc;
    rst = 1'b1; cyc; rst = 1'b0;
    req = 3'b101;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("burst_gnt", gnt, ((i / 4) % 2) ? 3'b100 : 3'b001);
      if (i > 0) chk("burst_rvalid", rvalid, (((i - 1) / 4) % 2) ? 3'b100 : 3'b001);
      cyc;
    end
    req = '0; cyc;
    rst = 1'b1; cyc; rst = 1'b0;
    req = 3'b010;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("solo_gnt", gnt, 3'b010);
      cyc;
    end
    req = 3'b111;
    #1;
    chk("sat_switch_gnt", gnt, 3'b100);
    cyc;
    req = '0; cyc;
    req = 3'b100; we = 3'b100; addr[2] = 32'h20; be[2] = 4'b0011; wdata[2] = 32'h12345678;
    #1;
    chk("wr_gnt", gnt, 3'b100);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_be", mem_be, 4'b0011);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    chk("wr_mem_addr", mem_addr, 32'h20);
    cyc;
    req = '0; we = '0;
    #1;
    chk("wr_rvalid", rvalid, 3'b100);
    chk("wr_idle_we", mem_we, 0);
    chk("wr_idle_req", mem_req, 0);
    cyc;
    addr[0] = 32'h40; req = 3'b001;
    #1;
    chk("pre_rst_gnt", gnt, 3'b001);
    cyc;
    req = '0; rst = 1'b1;
    #1;
    chk("rst_drop_rvalid", rvalid, 0);
    chk("rst_drop_mem_req", mem_req, 0);
    cyc;
    rst = 1'b0; req = 3'b011;
    #1;
    chk("post_rst_rvalid", rvalid, 0);
    chk("post_rst_gnt", gnt, 3'b001);
    cyc;
    req = '0;
    #1;
    chk("post_rst_rsp", rvalid, 3'b001);
    cyc;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mvu_mem_port_arbiter.md
# mvu_mem_port_arbiter

Arbitrates N requesters onto one single-port SRAM with fixed one-cycle read latency, e.g. the pito data memory shared between its AXI-to-memory bridge and the core load/store unit, or one MVU RAM bank shared between the AXI path and the MVU datapath. Uses a req/gnt/rvalid handshake on every port and enforces round-robin fairness with a bounded burst hold. Returns one response per grant, reads and writes alike, to the requester that owns it. Sits between the requesters and the memory macro inside the memory subsystem.

## Interface
- NumReq, 3, number of requesters (2..8)
- AddrWidth, 32, address width
- DataWidth, 32, data width; byte enables are DataWidth/8 bits
- MaxBurst, 4, max consecutive grants to one requester while others wait (1..15)
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- req_i  in  NumReq  per-requester request
- we_i  in  NumReq  per-requester write enable
- addr_i  in  NumReq x AddrWidth  per-requester address
- be_i  in  NumReq x DataWidth/8  per-requester byte enables
- wdata_i  in  NumReq x DataWidth  per-requester write data
- gnt_o  out  NumReq  grant; at most one bit high
- rvalid_o  out  NumReq  response valid, one per grant
- rdata_o  out  DataWidth  read data, broadcast to all requesters, qualified by rvalid_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  AddrWidth  memory address
- mem_be_o  out  DataWidth/8  memory byte enables
- mem_wdata_o  out  DataWidth  memory write data
- mem_rdata_i  in  DataWidth  memory read data, valid the cycle after mem_req_o

## Operation
- Grant is combinational from req_i and state. Granted requester's we/addr/be/wdata are muxed onto the mem_* outputs in the same cycle.
- mem_req_o = |gnt_o. With no grant, mem_we_o/be_o are 0 and the addr/wdata mux is held.
- Round-robin arbitration: search starts at index last_q+1 and wraps modulo NumReq. On every grant, last_q is updated to the granted index.
- Burst hold, FSM {IDLE, HOLD}:
  - IDLE: any grant moves to HOLD with owner_q=idx and cnt_q=1.
  - HOLD: if req_i[owner_q] is high and cnt_q<MaxBurst, owner_q is granted again and cnt_q increments.
  - HOLD: if owner_q drops req, or cnt_q==MaxBurst and another requester is pending, round-robin excluding owner_q applies. A new winner reloads owner_q/cnt_q=1. No request moves to IDLE.
  - HOLD: if cnt_q==MaxBurst and no other requester is pending, owner_q keeps its grant and cnt_q saturates at MaxBurst.
- Response tracking: rsp_v_q<=mem_req_o and rsp_idx_q<=granted index, registered each cycle. rvalid_o[rsp_idx_q]=rsp_v_q. rdata_o=mem_rdata_i, passed combinationally. Writes also produce rvalid, and rdata is don't-care for them.
- Back-to-back grants give back-to-back rvalids in grant order. No buffering is needed because latency is fixed.

## Timing
- Request-to-grant latency 0 cycles; grant-to-rvalid latency exactly 1 cycle. Throughput is 1 access/cycle.
- A requester must hold req_i and its payload stable until gnt_o. It may deassert, or issue a new request, in the cycle after the grant.
- Reset values: last_q=NumReq-1 (so index 0 wins first), FSM=IDLE, owner_q=0, cnt_q=0, rsp_v_q=0, rsp_idx_q=0. Result: all gnt_o/rvalid_o=0 and mem_req_o=0 while rst_i is high.
- Reset mid-operation: a response in flight is dropped and no rvalid_o follows reset. Requesters must discard outstanding transactions.
- Simultaneous requests from all ports: grants follow round-robin order, modulated by burst hold.
- cnt_q is 4 bits and never wraps.

## Configuration
- MVU_MEM_ARB_FIXED_PRIO_EN defined: priority is fixed, lowest index wins; burst hold and last_q are compiled out; cnt_q/owner_q are absent. Requester 0 can starve the others (intended for the core-first dmem path).
- Macro undefined: round-robin with burst hold, as described above.

## Structure
- mvu_pkg gets arb_state_e {IDLE, HOLD} and localparam ArbCntWidth=4.
- One sub-module, mvu_rr_pick: combinational rotate-and-priority-encode that takes a request vector, start index and exclude mask and returns idx plus valid. The top level holds the FSM, muxes and response register.

## Test plan
- Single requester 1 reads addr 0x10 with mem_rdata_i=0xDEADBEEF: gnt_o=3'b010 in the same cycle, rvalid_o=3'b010 and rdata_o=0xDEADBEEF one cycle later.
- All three requesters hold req, MaxBurst=1: grant sequence 0,1,2,0,1,2. Each rvalid follows its grant by 1 cycle to the same index.
- MaxBurst=4, requesters 0 and 2 hold req continuously: 0 is granted 4 times, then 2 is granted 4 times, repeating. cnt_q reaches 4 and no more.
- Requester 1 alone holds req for 10 cycles, MaxBurst=4: 10 consecutive grants, cnt_q saturates at 4.
- Write from requester 2 with be=4'b0011, wdata=0x12345678: mem_we_o=1, mem_be_o=4'b0011, and rvalid_o[2] one cycle later.
- rst_i asserted the cycle after a read grant: no rvalid_o, all outputs 0. After release, requester 0 wins a simultaneous 0/1 request.
